mem_stage_ctrl: RTL and testbench

//  Consumer side of the EX/MEM pipeline register: takes latched EX/MEM fields, runs data-memory
//  req/ack handshake, stalls upstream (drives EX/MEM en low) while memory is busy, and loads
//  MEM/WB outputs (writeback data select included). Sticky error/halt states stop the pipe cleanly.

---
 rtl/mem_stage_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumes the EX/MEM register, runs the data-memory req/ack handshake,
// stalls upstream while memory is busy and loads the MEM/WB register; halt and timeout are sticky.
module mem_stage_ctrl #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_aluResult,
    input  logic [DW-1:0] ex_B,
    input  logic [DW-1:0] ex_nextPC,
    input  logic [2:0]    ex_regsel,
    input  logic          ex_enJAL,
    input  logic          ex_mem_to_reg,
    input  logic          ex_memWrite,
    input  logic          ex_regWrite,
    input  logic          ex_halt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    wb_regsel,
    output logic          wb_regWrite,
    output logic          wb_halt,
    output logic          mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_cnt_nxt;
    logic            w_run;
    logic            w_access;
    logic            w_wait;
    logic            w_stall;
    logic            w_load;
    logic [DW-1:0]   w_wb_data_nxt;

    logic            r_wb_valid;
    logic [DW-1:0]   r_wb_data;
    logic [2:0]      r_wb_regsel;
    logic            r_wb_regWrite;
    logic            r_wb_halt;
    logic            r_mem_err;

    // Handshake qualification; rst gates the request so it drops the moment reset asserts.
    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_access = rst & w_run & ex_valid & (ex_memWrite | ex_mem_to_reg);
        w_wait   = w_access & ~mem_ack;
        w_stall  = w_wait | (rst & ~w_run);
        w_load   = w_run & ~w_stall;
    end

    // Next state, wait counter and writeback data select.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        w_wb_data_nxt  = ex_aluResult;

        case (r_state)
            ST_RUN: begin
                if (w_wait && (r_wait_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_ERR;
                end else if (w_load && ex_valid && ex_halt) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            ST_ERR:    w_state_nxt = ST_ERR;
            default:   w_state_nxt = ST_ERR;
        endcase

        if (w_wait) begin
            if (r_wait_cnt != CNT_MAX) begin
                w_wait_cnt_nxt = r_wait_cnt + CW'(1);
            end else begin
                w_wait_cnt_nxt = r_wait_cnt;
            end
        end else begin
            w_wait_cnt_nxt = '0;
        end

        if (ex_enJAL) begin
            w_wb_data_nxt = ex_nextPC;
        end else if (ex_mem_to_reg) begin
            w_wb_data_nxt = mem_rdata;
        end else begin
            w_wb_data_nxt = ex_aluResult;
        end
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= (w_state_nxt == ST_ERR);
        end
    end

    // MEM/WB register: load when flowing, otherwise insert a bubble and hold data/regsel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_regsel   <= 3'd0;
            r_wb_regWrite <= 1'b0;
            r_wb_halt     <= 1'b0;
        end else if (w_load) begin
            r_wb_valid    <= ex_valid;
            r_wb_data     <= w_wb_data_nxt;
            r_wb_regsel   <= ex_regsel;
            r_wb_regWrite <= ex_valid & ex_regWrite;
            r_wb_halt     <= ex_valid & ex_halt;
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regWrite <= 1'b0;
            r_wb_halt     <= 1'b0;
        end
    end

    assign mem_req     = w_access;
    assign mem_we      = ex_memWrite;
    assign mem_addr    = ex_aluResult;
    assign mem_wdata   = ex_B;
    assign stall       = w_stall;
    assign wb_valid    = r_wb_valid;
    assign wb_data     = r_wb_data;
    assign wb_regsel   = r_wb_regsel;
    assign wb_regWrite = r_wb_regWrite;
    assign wb_halt     = r_wb_halt;
    assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a behavioural pipeline model.
module tb_mem_stage_ctrl;

    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic [DW-1:0] ex_aluResult = '0;
    logic [DW-1:0] ex_B = '0;
    logic [DW-1:0] ex_nextPC = '0;
    logic [2:0]    ex_regsel = 3'd0;
    logic          ex_enJAL = 1'b0;
    logic          ex_mem_to_reg = 1'b0;
    logic          ex_memWrite = 1'b0;
    logic          ex_regWrite = 1'b0;
    logic          ex_halt = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [2:0]    wb_regsel;
    logic          wb_regWrite;
    logic          wb_halt;
    logic          mem_err;

    mem_stage_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_aluResult(ex_aluResult), .ex_B(ex_B),
        .ex_nextPC(ex_nextPC), .ex_regsel(ex_regsel), .ex_enJAL(ex_enJAL),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
        .ex_halt(ex_halt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_regsel(wb_regsel),
        .wb_regWrite(wb_regWrite), .wb_halt(wb_halt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model of the pipeline: flags plus a count of consecutive unacknowledged request cycles.
    bit            m_halted, m_err;
    int            m_waits;
    bit            m_wb_valid, m_wb_rw, m_wb_halt;
    logic [DW-1:0] m_wb_data;
    logic [2:0]    m_wb_regsel;

    int            delay;
    int            held;
    bit            fix_rdata = 1'b0;
    logic [DW-1:0] fix_val = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0; m_err = 1'b0; m_waits = 0;
        m_wb_valid = 1'b0; m_wb_rw = 1'b0; m_wb_halt = 1'b0;
        m_wb_data = '0; m_wb_regsel = 3'd0;
    endtask

    task automatic set_instr(input bit v, input bit ld, input bit st, input bit jal, input bit rw,
                             input bit hlt, input logic [DW-1:0] alu, input logic [DW-1:0] b,
                             input logic [DW-1:0] npc, input logic [2:0] rs, input int dly);
        ex_valid = v; ex_mem_to_reg = ld; ex_memWrite = st; ex_enJAL = jal; ex_regWrite = rw;
        ex_halt = hlt; ex_aluResult = alu; ex_B = b; ex_nextPC = npc; ex_regsel = rs;
        delay = dly; held = 0;
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check registers.
    task automatic run_cycle(output bit stalled, output bit req);
        bit running, is_mem, busy, m_stall;
        is_mem    = ex_valid && (ex_memWrite || ex_mem_to_reg);
        mem_ack   = is_mem && (held >= delay);
        mem_rdata = fix_rdata ? fix_val : DW'($urandom);
        #1;
        running = !m_halted && !m_err;
        req     = running && is_mem;
        busy    = req && !mem_ack;
        m_stall = busy || !running;
        check_eq("mem_req", {31'd0, mem_req}, {31'd0, req});
        check_eq("stall", {31'd0, stall}, {31'd0, m_stall});
        if (req) begin
            check_eq("mem_we", {31'd0, mem_we}, {31'd0, ex_memWrite});
            check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, ex_aluResult});
            check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, ex_B});
        end
        @(posedge clk);
        if (running && !m_stall) begin
            m_wb_valid  = ex_valid;
            m_wb_regsel = ex_regsel;
            m_wb_rw     = ex_valid && ex_regWrite;
            m_wb_halt   = ex_valid && ex_halt;
            m_wb_data   = ex_enJAL ? ex_nextPC : (ex_mem_to_reg ? mem_rdata : ex_aluResult);
            if (ex_valid && ex_halt) m_halted = 1'b1;
        end else begin
            m_wb_valid = 1'b0; m_wb_rw = 1'b0; m_wb_halt = 1'b0;
        end
        if (busy) begin
            m_waits++;
            if (m_waits >= TIMEOUT) m_err = 1'b1;
        end else begin
            m_waits = 0;
        end
        #1;
        check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_valid});
        check_eq("wb_regWrite", {31'd0, wb_regWrite}, {31'd0, m_wb_rw});
        check_eq("wb_halt", {31'd0, wb_halt}, {31'd0, m_wb_halt});
        check_eq("wb_data", {16'd0, wb_data}, {16'd0, m_wb_data});
        check_eq("wb_regsel", {29'd0, wb_regsel}, {29'd0, m_wb_regsel});
        check_eq("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        @(negedge clk);
        held++;
        stalled = m_stall;
    endtask

    // Present the current instruction until the model says it has moved on (bounded).
    task automatic run_instr(input int max_cyc, output int n_stall, output int n_req, output bit done);
        bit s, r;
        n_stall = 0; n_req = 0; done = 1'b0; held = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            run_cycle(s, r);
            if (s) n_stall++;
            if (r) n_req++;
            if (!s) done = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wb_regWrite", {31'd0, wb_regWrite}, 32'd0);
        check_eq("rst_wb_halt", {31'd0, wb_halt}, 32'd0);
        check_eq("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check_eq("rst_mem_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        held = 0;
    endtask

    initial begin
        int  ns, nr;
        bit  dn;
        bit  s, r;
        int  k, dsel, dly;
        model_reset();
        @(negedge clk);
        do_reset();

        // Load with zero-wait ack
        fix_rdata = 1'b1; fix_val = 16'hBEEF;
        set_instr(1, 1, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'h0002, 3'd3, 0);
        run_instr(4, ns, nr, dn);
        check_eq("t1_nostall", ns, 0);
        check_eq("t1_wb_data", {16'd0, wb_data}, 32'h0000BEEF);
        check_eq("t1_wb_regsel", {29'd0, wb_regsel}, 32'd3);
        check_eq("t1_wb_rw", {31'd0, wb_regWrite}, 32'd1);
        fix_rdata = 1'b0;

        // Store acked after 3 wait cycles
        set_instr(1, 0, 1, 0, 0, 0, 16'h0010, 16'h1234, 16'h0004, 3'd1, 3);
        run_instr(10, ns, nr, dn);
        check_eq("t2_done", {31'd0, dn}, 32'd1);
        check_eq("t2_stall_cycles", ns, 3);
        check_eq("t2_wb_rw", {31'd0, wb_regWrite}, 32'd0);

        // Load + halt at the acceptance boundary of TIMEOUT-1 waits: completes, then halts
        set_instr(1, 1, 0, 0, 1, 1, 16'h0080, 16'h0000, 16'h0006, 3'd5, TIMEOUT - 1);
        run_instr(TIMEOUT + 5, ns, nr, dn);
        check_eq("t5b_done", {31'd0, dn}, 32'd1);
        check_eq("t5b_stall_cycles", ns, TIMEOUT - 1);
        check_eq("t5b_wb_halt", {31'd0, wb_halt}, 32'd1);
        check_eq("t5b_no_err", {31'd0, mem_err}, 32'd0);
        set_instr(1, 0, 0, 0, 1, 0, 16'h0001, 16'h0000, 16'h0008, 3'd2, 0);
        run_instr(5, ns, nr, dn);
        check_eq("t5b_frozen", ns, 5);
        do_reset();

        // JAL writes back nextPC, no memory request
        set_instr(1, 0, 0, 1, 1, 0, 16'h0100, 16'h0000, 16'h0022, 3'd7, 0);
        run_instr(4, ns, nr, dn);
        check_eq("t4_no_req", nr, 0);
        check_eq("t4_wb_data", {16'd0, wb_data}, 32'h00000022);

        // Halt followed by more valid ops
        set_instr(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h000A, 3'd0, 0);
        run_instr(4, ns, nr, dn);
        check_eq("t5_wb_halt", {31'd0, wb_halt}, 32'd1);
        set_instr(1, 0, 0, 0, 1, 0, 16'h0005, 16'h0000, 16'h000C, 3'd4, 0);
        run_instr(6, ns, nr, dn);
        check_eq("t5_stall_forever", ns, 6);
        check_eq("t5_no_wb_valid", {31'd0, wb_valid}, 32'd0);
        do_reset();

        // Load never acked: times out after TIMEOUT wait cycles
        set_instr(1, 1, 0, 0, 1, 0, 16'h0200, 16'h0000, 16'h000E, 3'd6, 100000);
        run_instr(TIMEOUT + 10, ns, nr, dn);
        check_eq("t3_req_cycles", nr, TIMEOUT);
        check_eq("t3_stuck", {31'd0, dn}, 32'd0);
        check_eq("t3_mem_err", {31'd0, mem_err}, 32'd1);
        do_reset();

        // Reset during a two-cycle wait, then a full TIMEOUT-1 wait must not time out
        set_instr(1, 1, 0, 0, 1, 0, 16'h0300, 16'h0000, 16'h0010, 3'd2, 10);
        run_cycle(s, r);
        run_cycle(s, r);
        mem_ack = 1'b0;
        #2;
        check_eq("t6_req_before", {31'd0, mem_req}, 32'd1);
        do_reset();
        set_instr(1, 1, 0, 0, 1, 0, 16'h0304, 16'h0000, 16'h0012, 3'd3, TIMEOUT - 1);
        run_instr(TIMEOUT + 5, ns, nr, dn);
        check_eq("t6_done", {31'd0, dn}, 32'd1);
        check_eq("t6_cnt_cleared", {31'd0, mem_err}, 32'd0);

        // Randomized instruction stream
        for (int it = 0; it < 400; it++) begin
            if (m_halted || m_err) begin
                run_instr(3, ns, nr, dn);
                do_reset();
            end
            k    = $urandom_range(0, 9);
            dsel = $urandom_range(0, 99);
            if (dsel < 70)      dly = $urandom_range(0, 3);
            else if (dsel < 95) dly = $urandom_range(TIMEOUT - 3, TIMEOUT);
            else                dly = 100000;
            set_instr($urandom_range(0, 99) < 85, k < 3, (k >= 3) && (k < 6),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 29) == 0, DW'($urandom), DW'($urandom),
                      DW'($urandom), 3'($urandom), dly);
            run_instr(TIMEOUT + 5, ns, nr, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
